// File: rtl/updown_mod_counter.sv
// Parametrised modulo-N up/down counter with step, wrap/saturate,
// range-checked parallel load and carry/borrow pulses for cascading.
module updown_mod_counter #(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 20,
    parameter int RST_VAL = 0,
    parameter int SW      = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PAUSE,
    input  logic             U_D,
    input  logic             SAT,
    input  logic [SW-1:0]    STEP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic             CLR_ERR,
    output logic [WIDTH-1:0] Q,
    output logic             CARRY,
    output logic             BORROW,
    output logic             AT_MAX,
    output logic             AT_ZERO,
    output logic             LOAD_ERR
);

    // One extra bit over the widest operand keeps Q + STEP from overflowing.
    localparam int EW = ((WIDTH > SW) ? WIDTH : SW) + 1;
    localparam logic [EW-1:0] MOD_E = EW'(MODULUS);
    localparam logic [EW-1:0] MAX_E = EW'(MODULUS - 1);

    logic [EW-1:0]    q_e;
    logic [EW-1:0]    step_e;
    logic [EW-1:0]    lv_e;
    logic [EW-1:0]    sum;
    logic [WIDTH-1:0] q_n;
    logic             c_n;
    logic             b_n;
    logic             load_ok;

    assign q_e     = EW'(Q);
    assign step_e  = EW'(STEP);
    assign lv_e    = EW'(LOAD_VAL);
    assign sum     = q_e + step_e;
    assign load_ok = (lv_e < MOD_E);

    always_comb begin
        q_n = Q;
        c_n = 1'b0;
        b_n = 1'b0;
        if (U_D) begin
            if (sum <= MAX_E) begin
                q_n = WIDTH'(sum);
            end else begin
                c_n = 1'b1;
                q_n = SAT ? WIDTH'(MAX_E) : WIDTH'(sum - MOD_E);
            end
        end else begin
            if (q_e >= step_e) begin
                q_n = WIDTH'(q_e - step_e);
            end else begin
                b_n = 1'b1;
                q_n = SAT ? '0 : WIDTH'(q_e + MOD_E - step_e);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            Q      <= WIDTH'(RST_VAL);
            CARRY  <= 1'b0;
            BORROW <= 1'b0;
        end else if (LOAD) begin
            if (load_ok) begin
                Q <= LOAD_VAL;
            end
            CARRY  <= 1'b0;
            BORROW <= 1'b0;
        end else if (PAUSE) begin
            CARRY  <= 1'b0;
            BORROW <= 1'b0;
        end else begin
            Q      <= q_n;
            CARRY  <= c_n;
            BORROW <= b_n;
        end
    end

    // A bad load on the same edge as a clear leaves the error visible.
    always_ff @(posedge CLK) begin
        if (RST) begin
            LOAD_ERR <= 1'b0;
        end else if (LOAD && !load_ok) begin
            LOAD_ERR <= 1'b1;
        end else if (CLR_ERR) begin
            LOAD_ERR <= 1'b0;
        end
    end

    assign AT_MAX  = (q_e == MAX_E);
    assign AT_ZERO = (Q == '0);

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
- Parametrised modulo-N up/down counter, successor to the fixed 8-bit mod-20 counter.
- Adds configurable width, modulus, reset value and run-time step size.
- Adds a run-time wrap/saturate mode, synchronous parallel load with range checking, and carry/borrow pulses for cascading.
- Used as the generic timebase/digit counter in display and timer datapaths.

Parameters:
- WIDTH, 8: counter width in bits; requires 2 <= MODULUS <= 2**WIDTH.
- MODULUS, 20: count range 0..MODULUS-1; MAX = MODULUS-1.
- RST_VAL, 0: value of Q after reset; requires RST_VAL < MODULUS.
- SW, 4: width of the STEP input.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- PAUSE  in  1  1 = hold Q; 0 = count.
- U_D  in  1  1 = count up; 0 = count down.
- SAT  in  1  0 = wrap mode; 1 = saturate mode.
- STEP  in  SW  increment/decrement magnitude. 0 holds Q. Values >= MODULUS are illegal; the bench must not drive them.
- LOAD  in  1  synchronous parallel load strobe.
- LOAD_VAL  in  WIDTH  value to load.
- CLR_ERR  in  1  clears LOAD_ERR.
- Q  out  WIDTH  counter value, registered.
- CARRY  out  1  registered one-cycle pulse on an up-boundary event.
- BORROW  out  1  registered one-cycle pulse on a down-boundary event.
- AT_MAX  out  1  combinational, Q == MAX.
- AT_ZERO  out  1  combinational, Q == 0.
- LOAD_ERR  out  1  sticky, registered; set by an out-of-range load.

Behaviour:
- Reset (CLK edge with RST=1): Q=RST_VAL, CARRY=0, BORROW=0, LOAD_ERR=0. Reset overrides every other input, including LOAD and CLR_ERR.
- Per-edge priority: RST > LOAD > PAUSE > count.
- LOAD=1 (PAUSE ignored):
  - LOAD_VAL < MODULUS: Q <= LOAD_VAL.
  - Otherwise: Q unchanged and LOAD_ERR <= 1.
  - CARRY=BORROW=0 in the cycle after any load.
- PAUSE=1 with no load: Q holds; CARRY=BORROW=0.
- Counting (PAUSE=0, LOAD=0): all arithmetic in WIDTH+1 bits, so no intermediate overflow.
  - Up: S = Q + STEP.
    - S <= MAX: Q <= S.
    - S > MAX, wrap mode: Q <= S - MODULUS and CARRY <= 1.
    - S > MAX, saturate mode: Q <= MAX and CARRY <= 1.
  - Down:
    - Q >= STEP: Q <= Q - STEP.
    - Q < STEP, wrap mode: Q <= Q + MODULUS - STEP and BORROW <= 1.
    - Q < STEP, saturate mode: Q <= 0 and BORROW <= 1.
  - Saturate mode pinned at a limit: CARRY (at MAX counting up) or BORROW (at 0 counting down) re-asserts every counting cycle while pinned.
  - STEP=0: Q holds, no pulse.
- CARRY/BORROW are valid in the same cycle the new Q appears, i.e. asserted on the edge that performs the boundary step. They deassert on the next edge unless the event repeats.
- CARRY and BORROW are never both 1.
- U_D, SAT and STEP may change on any cycle; each edge uses the values sampled at that edge.
- LOAD_ERR:
  - Cleared by CLR_ERR=1.
  - If CLR_ERR and an out-of-range LOAD occur on the same edge, the set wins (LOAD_ERR=1).
- Latency: 1 cycle from input to Q, CARRY and BORROW. AT_MAX and AT_ZERO follow Q with no added latency.
- Defaults (WIDTH=8, MODULUS=20, STEP=1, SAT=0) reproduce the legacy mod-20 counter's sequence. The legacy block had no equivalents of CARRY, BORROW, AT_MAX, AT_ZERO or LOAD_ERR.

Test Plan:
- Reset then count up: RST 1 cycle, PAUSE=0, U_D=1, STEP=1, SAT=0, 22 edges -> Q goes 0..19 then 0,1. CARRY=1 only on the edge Q returns to 0. AT_MAX=1 while Q=19.
- Wrap with step: load 18, STEP=3, up -> Q=1 with CARRY=1. Load 1, down STEP=3 -> Q=18 with BORROW=1. Down STEP=1 from 0 -> Q=19 with BORROW=1.
- Saturate: SAT=1, load 18, up STEP=3 -> Q=19 with CARRY=1. Two further edges -> Q=19 with CARRY=1 each. Reverse U_D=0 STEP=5 from 3 -> Q=0 with BORROW=1.
- Pause/step-zero hold: Q=7, PAUSE=1 for 5 edges -> Q=7, no pulses. PAUSE=0, STEP=0 -> Q=7. PAUSE=1 with LOAD=1, LOAD_VAL=12 -> Q=12.
- Load range check: Q=5, LOAD_VAL=25 -> Q=5 and LOAD_ERR=1, held across 10 edges. CLR_ERR together with LOAD_VAL=20 -> LOAD_ERR stays 1. CLR_ERR alone -> LOAD_ERR=0.
- Reset priority mid-operation: Q=15 counting with LOAD=1, LOAD_VAL=3, RST=1 on the same edge -> Q=0, CARRY=BORROW=LOAD_ERR=0. Counting resumes 1,2,... next edges.
